// File: rtl/nec_frame_formatter.sv
`default_nettype none
// ============================================================================
// Module      : nec_frame_formatter
// Description : Validates decoded NEC IR frames / repeat events, queues one
//               event in a holding slot and streams an ASCII line for it to a
//               UART transmitter over a wr_en/busy handshake. Also latches the
//               last good address/command.
// Revision    : 1.0 - initial release
// ============================================================================
module nec_frame_formatter #(
    parameter int EXT_ADDR    = 0,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] frame_data,
    input  logic        frame_valid,
    input  logic        repeat_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_wr_en,
    output logic [7:0]  cmd_out,
    output logic [15:0] addr_out,
    output logic        cmd_valid,
    output logic        err_flag,
    output logic        ovf_flag
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_IDLE = 2'd3
    } state_t;

    localparam logic [1:0] c_type_good = 2'd0;
    localparam logic [1:0] c_type_bad  = 2'd1;
    localparam logic [1:0] c_type_rep  = 2'd2;
    localparam logic [9:0] c_ack_limit = 10'(ACK_TIMEOUT);

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Index of the final byte (LF) of a message of the given type.
    function automatic logic [3:0] last_idx(input logic [1:0] typ);
        if (typ == c_type_good)
            return (EXT_ADDR != 0) ? 4'd8 : 4'd6;
        return 4'd2;
    endfunction

    // Byte 'idx' of the ASCII line for a message. The index is one bit wider
    // than 3 so the 9-byte extended-address line never wraps.
    function automatic logic [7:0] msg_byte(input logic [1:0] typ, input logic [31:0] frm,
                                            input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (typ == c_type_good) begin
            if (EXT_ADDR != 0) begin
                case (idx)
                    4'd0:    b = hex_char(frm[15:12]);
                    4'd1:    b = hex_char(frm[11:8]);
                    4'd2:    b = hex_char(frm[7:4]);
                    4'd3:    b = hex_char(frm[3:0]);
                    4'd4:    b = 8'h20;
                    4'd5:    b = hex_char(frm[23:20]);
                    4'd6:    b = hex_char(frm[19:16]);
                    4'd7:    b = 8'h0D;
                    default: b = 8'h0A;
                endcase
            end else begin
                case (idx)
                    4'd0:    b = hex_char(frm[7:4]);
                    4'd1:    b = hex_char(frm[3:0]);
                    4'd2:    b = 8'h20;
                    4'd3:    b = hex_char(frm[23:20]);
                    4'd4:    b = hex_char(frm[19:16]);
                    4'd5:    b = 8'h0D;
                    default: b = 8'h0A;
                endcase
            end
        end else begin
            case (idx)
                4'd0:    b = (typ == c_type_bad) ? 8'h45 : 8'h52;
                4'd1:    b = 8'h0D;
                default: b = 8'h0A;
            endcase
        end
        return b;
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic        r_slot_full;
    logic [1:0]  r_slot_type;
    logic [31:0] r_slot_frame;
    logic [1:0]  r_msg_type;
    logic [31:0] r_msg_frame;
    logic [3:0]  r_idx;
    logic [9:0]  r_ack_cnt;
    logic [7:0]  r_tx_data;
    logic        w_frame_ok;
    logic        w_event;
    logic        w_capture;
    logic        w_drop;
    logic        w_good_cap;
    logic [1:0]  w_cap_type;
    logic        w_load;
    logic        w_advance;
    logic [1:0]  w_nxt_type;
    logic [31:0] w_nxt_frame;
    logic [3:0]  w_nxt_idx;

    // Event classification and holding-slot admission.
    always_comb begin
        w_frame_ok = (frame_data[31:24] == ~frame_data[23:16]) &&
                     ((EXT_ADDR != 0) || (frame_data[15:8] == ~frame_data[7:0]));
        w_event    = frame_valid | repeat_valid;
        w_capture  = w_event && !r_slot_full;
        // A repeat coinciding with a frame loses and is counted as dropped.
        w_drop     = (w_event && r_slot_full) || (frame_valid && repeat_valid);
        w_cap_type = frame_valid ? (w_frame_ok ? c_type_good : c_type_bad) : c_type_rep;
        w_good_cap = w_capture && frame_valid && w_frame_ok;
    end

    // Next-state logic for the byte streaming FSM.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_slot_full && !tx_busy) begin
                    w_load       = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                w_state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy || (r_ack_cnt == c_ack_limit))
                    w_state_next = S_WAIT_IDLE;
            end
            default: begin
                if (!tx_busy) begin
                    if (r_idx == last_idx(r_msg_type)) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = S_SEND;
                    end
                end
            end
        endcase
        w_nxt_type  = w_load ? r_slot_type  : r_msg_type;
        w_nxt_frame = w_load ? r_slot_frame : r_msg_frame;
        w_nxt_idx   = w_load ? 4'd0 : (r_idx + 4'd1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    // Holding slot: filled by an admitted event, emptied when its message starts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_slot_full  <= 1'b0;
            r_slot_type  <= c_type_good;
            r_slot_frame <= 32'h0;
        end else begin
            if (w_load)
                r_slot_full <= 1'b0;
            if (w_capture) begin
                r_slot_full  <= 1'b1;
                r_slot_type  <= w_cap_type;
                r_slot_frame <= frame_data;
            end
        end
    end

    // Message register, byte index and the held transmit byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_msg_type  <= c_type_good;
            r_msg_frame <= 32'h0;
            r_idx       <= 4'd0;
            r_tx_data   <= 8'h00;
        end else if (w_load || w_advance) begin
            r_msg_type  <= w_nxt_type;
            r_msg_frame <= w_nxt_frame;
            r_idx       <= w_nxt_idx;
            r_tx_data   <= msg_byte(w_nxt_type, w_nxt_frame, w_nxt_idx);
        end
    end

    // Acknowledge timeout: counts cycles spent waiting for tx_busy to rise.
    always_ff @(posedge clk) begin
        if (!rst || (r_state != S_WAIT_ACK)) r_ack_cnt <= 10'd0;
        else                                 r_ack_cnt <= r_ack_cnt + 10'd1;
    end

    // Last-good latch, update pulse and sticky status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_out   <= 8'h00;
            addr_out  <= 16'h0000;
            cmd_valid <= 1'b0;
            err_flag  <= 1'b0;
            ovf_flag  <= 1'b0;
        end else begin
            cmd_valid <= w_good_cap;
            if (w_good_cap) begin
                cmd_out  <= frame_data[23:16];
                addr_out <= (EXT_ADDR != 0) ? frame_data[15:0] : {8'h00, frame_data[7:0]};
            end
            if (w_capture && frame_valid && !w_frame_ok)
                err_flag <= 1'b1;
            if (w_drop)
                ovf_flag <= 1'b1;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_wr_en = (r_state == S_SEND);

endmodule
`default_nettype wire

// File: tb/tb_nec_frame_formatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nec_frame_formatter
// Description : Directed self-checking bench for nec_frame_formatter with a
//               simple UART busy model and a byte/strobe monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nec_frame_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] frame_data = 32'h0;
    logic        frame_valid = 1'b0;
    logic        repeat_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_wr_en;
    logic [7:0]  cmd_out;
    logic [15:0] addr_out;
    logic        cmd_valid;
    logic        err_flag;
    logic        ovf_flag;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          t_evt   = 0;
    int          cv_cnt  = 0;
    int          busy_cnt = 0;
    bit          model_on = 1'b1;
    logic [7:0]  rx_q[$];
    int          rx_t[$];

    localparam logic [31:0] c_frm_a = 32'hE31CFF00;  // addr 00 cmd 1C
    localparam logic [31:0] c_frm_b = 32'hF708FB04;  // addr 04 cmd 08
    localparam logic [31:0] c_frm_c = 32'hBA45BF40;  // addr 40 cmd 45
    localparam logic [31:0] c_frm_x = 32'hE31DFF00;  // bad ~cmd

    nec_frame_formatter #(.EXT_ADDR(0), .ACK_TIMEOUT(1023)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .repeat_valid (repeat_valid),
        .tx_busy      (tx_busy),
        .tx_data      (tx_data),
        .tx_wr_en     (tx_wr_en),
        .cmd_out      (cmd_out),
        .addr_out     (addr_out),
        .cmd_valid    (cmd_valid),
        .err_flag     (err_flag),
        .ovf_flag     (ovf_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor strobes/pulses and model a UART that is busy 10 cycles per byte.
    always @(negedge clk) begin
        if (tx_wr_en) begin
            rx_q.push_back(tx_data);
            rx_t.push_back(cyc);
        end
        if (cmd_valid) cv_cnt = cv_cnt + 1;
        if (model_on) begin
            if (tx_wr_en)          busy_cnt = 10;
            else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        end else begin
            busy_cnt = 0;
        end
        tx_busy = (busy_cnt != 0);
    end

    task automatic send_frame(input logic [31:0] f, input bit with_rep);
        @(negedge clk);
        frame_data   = f;
        frame_valid  = 1'b1;
        repeat_valid = with_rep;
        t_evt        = cyc;
        @(negedge clk);
        frame_valid  = 1'b0;
        repeat_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while ((rx_q.size() < n) && (k < budget)) begin
            @(posedge clk);
            k++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (tx_wr_en !== 1'b0)   begin n_fail++; $display("FAIL rst_wr_en got %h want 0", tx_wr_en); end
        n_tests++; if (tx_data !== 8'h00)   begin n_fail++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
        n_tests++; if (cmd_out !== 8'h00)   begin n_fail++; $display("FAIL rst_cmd got %h want 00", cmd_out); end
        n_tests++; if (addr_out !== 16'h0)  begin n_fail++; $display("FAIL rst_addr got %h want 0000", addr_out); end
        n_tests++; if (cmd_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_cmd_valid got %h want 0", cmd_valid); end
        n_tests++; if (err_flag !== 1'b0)   begin n_fail++; $display("FAIL rst_err got %h want 0", err_flag); end
        n_tests++; if (ovf_flag !== 1'b0)   begin n_fail++; $display("FAIL rst_ovf got %h want 0", ovf_flag); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL rst_no_strobe got %0d want 0", rx_q.size()); end
    endtask

    task automatic test_good();
        logic [7:0] e [7] = '{8'h30, 8'h30, 8'h20, 8'h31, 8'h43, 8'h0D, 8'h0A};
        int cv0;
        cv0 = cv_cnt;
        rx_q.delete(); rx_t.delete();
        send_frame(c_frm_a, 1'b0);
        wait_rx(7, 300);
        repeat (15) @(negedge clk);
        n_tests++; if (rx_q.size() != 7) begin n_fail++; $display("FAIL good_len got %0d want 7", rx_q.size()); end
        for (int i = 0; i < 7 && i < rx_q.size(); i++) begin
            n_tests++;
            if (rx_q[i] !== e[i]) begin n_fail++; $display("FAIL good_byte%0d got %h want %h", i, rx_q[i], e[i]); end
        end
        if (rx_t.size() > 0) begin
            n_tests++;
            if (rx_t[0] - t_evt != 2) begin n_fail++; $display("FAIL good_latency got %0d want 2", rx_t[0] - t_evt); end
        end
        n_tests++; if (cmd_out !== 8'h1C)     begin n_fail++; $display("FAIL good_cmd got %h want 1C", cmd_out); end
        n_tests++; if (addr_out !== 16'h0000) begin n_fail++; $display("FAIL good_addr got %h want 0000", addr_out); end
        n_tests++; if (cv_cnt - cv0 != 1)     begin n_fail++; $display("FAIL good_cmd_valid got %0d want 1", cv_cnt - cv0); end
        n_tests++; if (err_flag !== 1'b0)     begin n_fail++; $display("FAIL good_err got %h want 0", err_flag); end
        n_tests++; if (tx_data !== 8'h0A)     begin n_fail++; $display("FAIL good_hold got %h want 0A", tx_data); end
    endtask

    task automatic test_bad();
        logic [7:0] e [3] = '{8'h45, 8'h0D, 8'h0A};
        int cv0;
        cv0 = cv_cnt;
        rx_q.delete(); rx_t.delete();
        send_frame(c_frm_x, 1'b0);
        wait_rx(3, 200);
        repeat (15) @(negedge clk);
        n_tests++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL bad_len got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            n_tests++;
            if (rx_q[i] !== e[i]) begin n_fail++; $display("FAIL bad_byte%0d got %h want %h", i, rx_q[i], e[i]); end
        end
        n_tests++; if (err_flag !== 1'b1)  begin n_fail++; $display("FAIL bad_err got %h want 1", err_flag); end
        n_tests++; if (cmd_out !== 8'h1C)  begin n_fail++; $display("FAIL bad_cmd_kept got %h want 1C", cmd_out); end
        n_tests++; if (cv_cnt != cv0)      begin n_fail++; $display("FAIL bad_no_valid got %0d want %0d", cv_cnt, cv0); end
    endtask

    task automatic test_repeat();
        logic [7:0] e [3] = '{8'h52, 8'h0D, 8'h0A};
        logic [7:0] f [7] = '{8'h34, 8'h30, 8'h20, 8'h34, 8'h35, 8'h0D, 8'h0A};
        rx_q.delete(); rx_t.delete();
        @(negedge clk);
        repeat_valid = 1'b1;
        @(negedge clk);
        repeat_valid = 1'b0;
        wait_rx(3, 200);
        repeat (15) @(negedge clk);
        n_tests++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL rep_len got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            n_tests++;
            if (rx_q[i] !== e[i]) begin n_fail++; $display("FAIL rep_byte%0d got %h want %h", i, rx_q[i], e[i]); end
        end
        n_tests++; if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL rep_ovf_clear got %h want 0", ovf_flag); end
        rx_q.delete(); rx_t.delete();
        send_frame(c_frm_c, 1'b1);
        wait_rx(7, 300);
        repeat (15) @(negedge clk);
        n_tests++; if (rx_q.size() != 7) begin n_fail++; $display("FAIL both_len got %0d want 7", rx_q.size()); end
        for (int i = 0; i < 7 && i < rx_q.size(); i++) begin
            n_tests++;
            if (rx_q[i] !== f[i]) begin n_fail++; $display("FAIL both_byte%0d got %h want %h", i, rx_q[i], f[i]); end
        end
        n_tests++; if (ovf_flag !== 1'b1)     begin n_fail++; $display("FAIL both_ovf got %h want 1", ovf_flag); end
        n_tests++; if (cmd_out !== 8'h45)     begin n_fail++; $display("FAIL both_cmd got %h want 45", cmd_out); end
        n_tests++; if (addr_out !== 16'h0040) begin n_fail++; $display("FAIL both_addr got %h want 0040", addr_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e [14] = '{8'h30, 8'h30, 8'h20, 8'h31, 8'h43, 8'h0D, 8'h0A,
                               8'h30, 8'h34, 8'h20, 8'h30, 8'h38, 8'h0D, 8'h0A};
        do_reset();
        send_frame(c_frm_a, 1'b0);
        wait_rx(1, 50);
        repeat (2) @(negedge clk);
        frame_data  = c_frm_b;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_data  = c_frm_c;
        @(negedge clk);
        frame_valid = 1'b0;
        wait_rx(14, 1000);
        repeat (100) @(negedge clk);
        n_tests++; if (rx_q.size() != 14) begin n_fail++; $display("FAIL b2b_len got %0d want 14", rx_q.size()); end
        for (int i = 0; i < 14 && i < rx_q.size(); i++) begin
            n_tests++;
            if (rx_q[i] !== e[i]) begin n_fail++; $display("FAIL b2b_byte%0d got %h want %h", i, rx_q[i], e[i]); end
        end
        n_tests++; if (ovf_flag !== 1'b1)     begin n_fail++; $display("FAIL b2b_ovf got %h want 1", ovf_flag); end
        n_tests++; if (cmd_out !== 8'h08)     begin n_fail++; $display("FAIL b2b_cmd got %h want 08", cmd_out); end
        n_tests++; if (addr_out !== 16'h0004) begin n_fail++; $display("FAIL b2b_addr got %h want 0004", addr_out); end
    endtask

    task automatic test_timeout();
        logic [7:0] e [7] = '{8'h30, 8'h34, 8'h20, 8'h30, 8'h38, 8'h0D, 8'h0A};
        model_on = 1'b0;
        repeat (3) @(negedge clk);
        rx_q.delete(); rx_t.delete();
        send_frame(c_frm_b, 1'b0);
        wait_rx(7, 9000);
        repeat (5) @(negedge clk);
        n_tests++; if (rx_q.size() != 7) begin n_fail++; $display("FAIL tmo_len got %0d want 7", rx_q.size()); end
        for (int i = 0; i < 7 && i < rx_q.size(); i++) begin
            n_tests++;
            if (rx_q[i] !== e[i]) begin n_fail++; $display("FAIL tmo_byte%0d got %h want %h", i, rx_q[i], e[i]); end
        end
        if (rx_t.size() >= 2) begin
            n_tests++;
            if (rx_t[1] - rx_t[0] != 1026) begin n_fail++; $display("FAIL tmo_gap got %0d want 1026", rx_t[1] - rx_t[0]); end
        end
        repeat (1100) @(negedge clk);
        model_on = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] e [7] = '{8'h30, 8'h34, 8'h20, 8'h30, 8'h38, 8'h0D, 8'h0A};
        rx_q.delete(); rx_t.delete();
        send_frame(c_frm_a, 1'b0);
        wait_rx(3, 200);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (tx_wr_en !== 1'b0)  begin n_fail++; $display("FAIL mid_wr_en got %h want 0", tx_wr_en); end
        n_tests++; if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL mid_tx_data got %h want 00", tx_data); end
        n_tests++; if (cmd_out !== 8'h00)  begin n_fail++; $display("FAIL mid_cmd got %h want 00", cmd_out); end
        n_tests++; if (addr_out !== 16'h0) begin n_fail++; $display("FAIL mid_addr got %h want 0000", addr_out); end
        n_tests++; if (err_flag !== 1'b0)  begin n_fail++; $display("FAIL mid_err got %h want 0", err_flag); end
        n_tests++; if (ovf_flag !== 1'b0)  begin n_fail++; $display("FAIL mid_ovf got %h want 0", ovf_flag); end
        rst = 1'b1;
        repeat (100) @(negedge clk);
        n_tests++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL mid_quiet got %0d want 3", rx_q.size()); end
        send_frame(c_frm_b, 1'b0);
        wait_rx(10, 400);
        repeat (15) @(negedge clk);
        n_tests++; if (rx_q.size() != 10) begin n_fail++; $display("FAIL mid_len got %0d want 10", rx_q.size()); end
        for (int i = 0; i < 7 && (i + 3) < rx_q.size(); i++) begin
            n_tests++;
            if (rx_q[i + 3] !== e[i]) begin n_fail++; $display("FAIL mid_byte%0d got %h want %h", i, rx_q[i + 3], e[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad();
        test_repeat();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
